// File: rtl/poly6_call_arbiter.sv
// Round-robin arbiter that shares one poly6 HLS component between N_REQ
// requesters. Only one call is in flight at a time: a requester is granted,
// its idx is issued through the start/busy handshake, the returndata is
// captured on done, and the result is held until the granted requester
// takes it.
module poly6_call_arbiter #(
  parameter int N_REQ       = 4,
  parameter int IDX_W       = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*IDX_W-1:0]   req_idx,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic                     comp_start,
  output logic [IDX_W-1:0]         comp_idx,
  input  logic                     comp_busy,
  input  logic                     comp_done,
  output logic                     comp_stall,
  input  logic [DATA_W-1:0]        comp_returndata,
  output logic                     timeout_err,
  output logic [CNT_W-1:0]         call_count
);

  localparam int PTR_W  = $clog2(N_REQ);
  localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]        state;
  // ptr holds the most recent grant; it doubles as the owner of the call in flight
  logic [PTR_W-1:0]  ptr;
  logic [WCNT_W-1:0] wait_cnt;

  logic              any_req;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand;
  int                scan_pos;

  // Round-robin search: first requester at or after ptr+1, wrapping modulo N_REQ
  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    cand      = '0;
    scan_pos  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_pos = int'(ptr) + k;
      if (scan_pos >= N_REQ) scan_pos = scan_pos - N_REQ;
      cand = PTR_W'(scan_pos);
      if (!any_req && req_valid[cand]) begin
        any_req   = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Handshake outputs decoded from state; req_ready is masked while reset is held
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == ST_IDLE && any_req && !reset) req_ready[grant_idx] = 1'b1;
    if (state == ST_RESP) rsp_valid[ptr] = 1'b1;
  end

  assign comp_start = (state == ST_ISSUE);
  assign comp_stall = (state != ST_WAIT);

  // Call sequencing FSM with idx/result capture, timeout watch and call counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= PTR_W'(N_REQ - 1);
      comp_idx    <= '0;
      rsp_data    <= '0;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      call_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            comp_idx <= req_idx[int'(grant_idx)*IDX_W +: IDX_W];
            ptr      <= grant_idx;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!comp_busy) begin
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (comp_done) begin
            rsp_data   <= comp_returndata;
            call_count <= call_count + CNT_W'(1);
            state      <= ST_RESP;
          end else if (wait_cnt != WCNT_W'(TIMEOUT_CYC)) begin
            // Counter saturates at the limit; the error flag stays set until reset
            wait_cnt <= wait_cnt + WCNT_W'(1);
            if (wait_cnt == WCNT_W'(TIMEOUT_CYC - 1)) timeout_err <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[ptr]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly6_call_arbiter.sv
// Bench for poly6_call_arbiter: a behavioural poly6 model answers calls with
// programmable busy/latency, a scoreboard queue holds expected responses.
module tb_poly6_call_arbiter;
  localparam int N_REQ = 4, IDX_W = 32, DATA_W = 32, TIMEOUT_CYC = 8, CNT_W = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N_REQ*IDX_W-1:0] req_idx;
  logic [DATA_W-1:0]      rsp_data, comp_returndata;
  logic                   comp_start, comp_busy, comp_done, comp_stall, timeout_err;
  logic [IDX_W-1:0]       comp_idx;
  logic [CNT_W-1:0]       call_count;

  poly6_call_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W),
                       .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_idx(req_idx),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .comp_start(comp_start), .comp_idx(comp_idx),
    .comp_busy(comp_busy), .comp_done(comp_done), .comp_stall(comp_stall),
    .comp_returndata(comp_returndata), .timeout_err(timeout_err),
    .call_count(call_count));

  always #5 clock = ~clock;

  typedef struct { int id; logic [DATA_W-1:0] data; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_fail = 0, exp_count = 0;

  int busy_cfg = 0, done_delay = 1;
  bit done_en = 1'b1, done_inject = 1'b0;
  int m_busy_cnt = 0, m_cnt = 0;
  bit m_active = 1'b0;
  logic [DATA_W-1:0] m_data;
  int start_cycles = 0, grant_pulses = 0, wait_cycles = 0;

  function automatic logic [DATA_W-1:0] poly_model(input logic [IDX_W-1:0] x);
    return x ^ 32'h0000_1231;
  endfunction

  function automatic exp_t mk(input int id, input logic [IDX_W-1:0] idx);
    mk.id = id;
    mk.data = poly_model(idx);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input int i);
    return N_REQ'(1) << i;
  endfunction

  // poly6 component model: busy for busy_cfg cycles, done done_delay cycles after accept
  initial begin
    comp_busy = 1'b0; comp_done = 1'b0; comp_returndata = '0; m_data = '0;
    forever begin
      @(negedge clock);
      comp_done = done_inject;
      if (reset) begin
        m_active = 1'b0; m_busy_cnt = 0; comp_busy = 1'b0;
      end else if (m_active) begin
        if (m_cnt > 0) m_cnt--;
        else if (done_en) begin
          comp_done = 1'b1; comp_returndata = m_data; m_active = 1'b0;
        end
      end else if (comp_start === 1'b1) begin
        if (m_busy_cnt < busy_cfg) begin
          comp_busy = 1'b1; m_busy_cnt++;
        end else begin
          comp_busy = 1'b0; m_busy_cnt = 0; m_active = 1'b1;
          m_cnt = done_delay - 1; m_data = poly_model(comp_idx);
        end
      end
    end
  end

  // Activity counters sampled mid-cycle
  initial forever begin
    @(negedge clock);
    if (comp_start === 1'b1) start_cycles++;
    if (req_ready !== '0) grant_pulses++;
    if (comp_stall === 1'b0) wait_cycles++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic request(input int id, input logic [IDX_W-1:0] idx);
    req_valid[id] = 1'b1;
    req_idx[id*IDX_W +: IDX_W] = idx;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    #1;
    for (int n = 0; n < 64; n++) begin
      if (req_ready !== '0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    #1;
    for (int n = 0; n < 64; n++) begin
      if (rsp_valid !== '0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0; done_inject = 1'b0;
    tick(); tick();
    reset = 1'b0; exp_count = 0; exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; rsp_ready = '0;
    tick(); tick();
    n_cmp++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    n_cmp++; if (comp_start !== 1'b0 || comp_stall !== 1'b1) begin n_fail++; $display("FAIL reset_comp: start=%b stall=%b want 0/1", comp_start, comp_stall); end
    n_cmp++; if (comp_idx !== '0) begin n_fail++; $display("FAIL reset_comp_idx: got %h want 0", comp_idx); end
    n_cmp++; if (timeout_err !== 1'b0 || call_count !== '0) begin n_fail++; $display("FAIL reset_status: err=%b count=%0d want 0/0", timeout_err, call_count); end
    req_valid = '0; reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok; exp_t e; int s0, w0, g0;
    busy_cfg = 0; done_delay = 3; done_en = 1'b1;
    s0 = start_cycles; w0 = wait_cycles; g0 = grant_pulses;
    request(2, 32'd5); exp_q.push_back(mk(2, 32'd5));
    wait_grant(ok);
    n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    tick(); req_valid = '0; #1;
    n_cmp++; if (comp_start !== 1'b1 || comp_idx !== 32'd5) begin n_fail++; $display("FAIL single_issue: start=%b idx=%h want 1/5", comp_start, comp_idx); end
    wait_rsp(ok);
    n_cmp++;
    if (!ok || exp_q.size() == 0) begin n_fail++; $display("FAIL single_rsp: valid=%b, want a response", rsp_valid); end
    else begin
      e = exp_q.pop_front(); exp_count++;
      if (rsp_valid !== onehot(e.id) || rsp_data !== e.data || call_count !== CNT_W'(exp_count)) begin
        n_fail++; $display("FAIL single_rsp: got v=%b d=%h c=%0d want v=%b d=%h c=%0d", rsp_valid, rsp_data, call_count, onehot(e.id), e.data, CNT_W'(exp_count)); end
    end
    rsp_ready = 4'b0100; tick(); rsp_ready = '0;
    n_cmp++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL single_release: rsp_valid=%b want 0", rsp_valid); end
    n_cmp++; if (start_cycles - s0 != 1 || wait_cycles - w0 != 3 || grant_pulses - g0 != 1) begin
      n_fail++; $display("FAIL single_counts: start=%0d wait=%0d grant=%0d want 1/3/1", start_cycles - s0, wait_cycles - w0, grant_pulses - g0); end
  endtask

  task automatic test_round_robin();
    bit ok; exp_t e; int g0;
    int order [5] = '{0, 1, 2, 3, 0};
    done_delay = 1; rsp_ready = '1; g0 = grant_pulses;
    for (int i = 0; i < N_REQ; i++) request(i, 32'h100 + i);
    for (int k = 0; k < 5; k++) begin
      wait_grant(ok);
      n_cmp++; if (req_ready !== onehot(order[k])) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, onehot(order[k])); end
      exp_q.push_back(mk(order[k], 32'h100 + order[k]));
      tick();
      wait_rsp(ok);
      if (k == 4) req_valid = '0;
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin n_fail++; $display("FAIL rr_rsp%0d: valid=%b, want a response", k, rsp_valid); end
      else begin
        e = exp_q.pop_front(); exp_count++;
        if (rsp_valid !== onehot(e.id) || rsp_data !== e.data || call_count !== CNT_W'(exp_count)) begin
          n_fail++; $display("FAIL rr_rsp%0d: got v=%b d=%h c=%0d want v=%b d=%h c=%0d", k, rsp_valid, rsp_data, call_count, onehot(e.id), e.data, CNT_W'(exp_count)); end
      end
    end
    tick(); tick(); rsp_ready = '0;
    n_cmp++; if (grant_pulses - g0 != 5) begin n_fail++; $display("FAIL rr_pulses: got %0d want 5", grant_pulses - g0); end
  endtask

  task automatic test_busy();
    bit ok; exp_t e; int s0, n;
    busy_cfg = 5; done_delay = 2;
    request(1, 32'h9); exp_q.push_back(mk(1, 32'h9));
    wait_grant(ok);
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL busy_grant: got %b want 0010", req_ready); end
    s0 = start_cycles;
    tick(); req_valid = '0;
    n = 0;
    while (comp_start === 1'b1 && n < 20) begin
      n_cmp++; if (comp_idx !== 32'h9) begin n_fail++; $display("FAIL busy_idx: got %h want 9", comp_idx); end
      tick(); n++;
    end
    wait_rsp(ok);
    n_cmp++;
    if (!ok || exp_q.size() == 0) begin n_fail++; $display("FAIL busy_rsp: valid=%b, want a response", rsp_valid); end
    else begin
      e = exp_q.pop_front(); exp_count++;
      if (rsp_valid !== onehot(e.id) || rsp_data !== e.data || call_count !== CNT_W'(exp_count)) begin
        n_fail++; $display("FAIL busy_rsp: got v=%b d=%h c=%0d want v=%b d=%h c=%0d", rsp_valid, rsp_data, call_count, onehot(e.id), e.data, CNT_W'(exp_count)); end
    end
    rsp_ready = 4'b0010; tick(); rsp_ready = '0;
    n_cmp++; if (start_cycles - s0 != 6) begin n_fail++; $display("FAIL busy_start_cycles: got %0d want 6", start_cycles - s0); end
    busy_cfg = 0;
  endtask

  task automatic test_resp_hold();
    bit ok; exp_t e;
    done_delay = 1; rsp_ready = '0;
    request(1, 32'h22); exp_q.push_back(mk(1, 32'h22));
    wait_grant(ok);
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL hold_grant: got %b want 0010", req_ready); end
    tick(); req_valid = '0; request(0, 32'h33);
    wait_rsp(ok);
    n_cmp++;
    if (!ok || exp_q.size() == 0) begin n_fail++; $display("FAIL hold_rsp: valid=%b, want a response", rsp_valid); end
    else begin
      e = exp_q.pop_front(); exp_count++;
      if (rsp_valid !== onehot(e.id) || rsp_data !== e.data || call_count !== CNT_W'(exp_count)) begin
        n_fail++; $display("FAIL hold_rsp: got v=%b d=%h c=%0d want v=%b d=%h c=%0d", rsp_valid, rsp_data, call_count, onehot(e.id), e.data, CNT_W'(exp_count)); end
    end
    rsp_ready = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (rsp_valid !== 4'b0010 || rsp_data !== poly_model(32'h22) || req_ready !== '0) begin
        n_fail++; $display("FAIL hold_cycle%0d: v=%b d=%h rdy=%b want 0010/%h/0000", i, rsp_valid, rsp_data, req_ready, poly_model(32'h22)); end
    end
    rsp_ready = 4'b0010; tick(); rsp_ready = '0; #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL hold_next_grant: got %b want 0001", req_ready); end
    exp_q.push_back(mk(0, 32'h33));
    tick(); req_valid = '0;
    wait_rsp(ok);
    n_cmp++;
    if (!ok || exp_q.size() == 0) begin n_fail++; $display("FAIL hold_rsp2: valid=%b, want a response", rsp_valid); end
    else begin
      e = exp_q.pop_front(); exp_count++;
      if (rsp_valid !== onehot(e.id) || rsp_data !== e.data || call_count !== CNT_W'(exp_count)) begin
        n_fail++; $display("FAIL hold_rsp2: got v=%b d=%h c=%0d want v=%b d=%h c=%0d", rsp_valid, rsp_data, call_count, onehot(e.id), e.data, CNT_W'(exp_count)); end
    end
    rsp_ready = 4'b0001; tick(); rsp_ready = '0;
  endtask

  task automatic test_timeout();
    bit ok; exp_t e; int n;
    done_en = 1'b0; done_delay = 1;
    request(3, 32'h40); exp_q.push_back(mk(3, 32'h40));
    wait_grant(ok);
    tick(); req_valid = '0;
    n = 0;
    while (comp_stall !== 1'b0 && n < 20) begin tick(); n++; end
    for (int i = 0; i < 7; i++) tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: err=%b want 0 after 7 wait cycles", timeout_err); end
    tick();
    n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_set: err=%b want 1 after 8 wait cycles", timeout_err); end
    tick(); tick(); tick();
    done_en = 1'b1;
    wait_rsp(ok);
    n_cmp++;
    if (!ok || exp_q.size() == 0) begin n_fail++; $display("FAIL timeout_rsp: valid=%b, want a response", rsp_valid); end
    else begin
      e = exp_q.pop_front(); exp_count++;
      if (rsp_valid !== onehot(e.id) || rsp_data !== e.data || call_count !== CNT_W'(exp_count)) begin
        n_fail++; $display("FAIL timeout_rsp: got v=%b d=%h c=%0d want v=%b d=%h c=%0d", rsp_valid, rsp_data, call_count, onehot(e.id), e.data, CNT_W'(exp_count)); end
    end
    rsp_ready = 4'b1000; tick(); rsp_ready = '0; tick();
    n_cmp++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: err=%b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid_call();
    bit ok; int n;
    done_delay = 20;
    request(0, 32'h50);
    wait_grant(ok);
    tick(); req_valid = '0;
    n = 0;
    while (comp_stall !== 1'b0 && n < 20) begin tick(); n++; end
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0; exp_count = 0;
    n_cmp++; if (req_ready !== '0 || rsp_valid !== '0 || comp_start !== 1'b0 || comp_stall !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ctrl: rdy=%b v=%b start=%b stall=%b want 0/0/0/1", req_ready, rsp_valid, comp_start, comp_stall); end
    n_cmp++; if (rsp_data !== '0 || comp_idx !== '0) begin n_fail++; $display("FAIL midrst_data: d=%h idx=%h want 0/0", rsp_data, comp_idx); end
    n_cmp++; if (timeout_err !== 1'b0 || call_count !== '0) begin n_fail++; $display("FAIL midrst_status: err=%b c=%0d want 0/0", timeout_err, call_count); end
    done_inject = 1'b1; tick(); done_inject = 1'b0; tick(); tick();
    n_cmp++; if (rsp_valid !== '0 || call_count !== '0 || comp_stall !== 1'b1) begin
      n_fail++; $display("FAIL midrst_late_done: v=%b c=%0d stall=%b want 0/0/1", rsp_valid, call_count, comp_stall); end
    done_delay = 1;
  endtask

  task automatic test_back_to_back();
    bit ok; exp_t e;
    rsp_ready = 4'b0100; done_delay = 1;
    for (int k = 0; k < 17; k++) begin
      request(2, 32'(k * 7 + 1)); exp_q.push_back(mk(2, 32'(k * 7 + 1)));
      wait_grant(ok);
      n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL b2b_grant%0d: got %b want 0100", k, req_ready); end
      tick(); req_valid = '0;
      wait_rsp(ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_rsp%0d: valid=%b, want a response", k, rsp_valid); end
      else begin
        e = exp_q.pop_front(); exp_count++;
        if (rsp_valid !== onehot(e.id) || rsp_data !== e.data || call_count !== CNT_W'(exp_count)) begin
          n_fail++; $display("FAIL b2b_rsp%0d: got v=%b d=%h c=%0d want v=%b d=%h c=%0d", k, rsp_valid, rsp_data, call_count, onehot(e.id), e.data, CNT_W'(exp_count)); end
      end
    end
    tick(); rsp_ready = '0;
    n_cmp++; if (call_count !== 4'd1) begin n_fail++; $display("FAIL b2b_wrap: count=%0d want 1 after 17 calls", call_count); end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_idx = '0; rsp_ready = '0; done_inject = 1'b0;
    test_reset();
    test_single();
    apply_reset();
    test_round_robin();
    test_busy();
    test_resp_hold();
    test_timeout();
    test_reset_mid_call();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
